half_subst: RTL and testbench

- Registered half subtractor. Computes the difference s = a XOR b and the borrow c = (NOT a) AND b.
- Operates bitwise over a parameterised lane width; each lane is an independent 1-bit half subtractor.
- Used as a leaf arithmetic cell feeding full-subtractor chains and lab datapaths.
- One clock domain. Registered outputs give a fixed one-cycle latency.

---
 rtl/half_subst.sv | 88 ++++++++
 tb/tb_half_subst.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/half_subst.sv
// half_subst: bitwise half subtractor with optional output registers.
//
// Each of the WIDTH lanes is an independent 1-bit half subtractor:
//     s[i] = a[i] ^ b[i]          (difference)
//     c[i] = ~a[i] & b[i]         (borrow out)
// so that a[i] - b[i] = s[i] - 2*c[i]. No borrow ever crosses lanes.
//
// Parameters:
//     WIDTH      number of lanes (1..64)
//     REGISTERED 1 = s/c/out_valid registered (one-cycle latency)
//                0 = s/c/out_valid combinational, gated to 0 during rst
//
// Ports:
//     clk        system clock, rising-edge active
//     rst        synchronous active-high reset
//     a, b       minuend / subtrahend, one bit per lane
//     in_valid   a/b qualify this cycle
//     s, c       difference / borrow per lane
//     out_valid  s/c hold a fresh result
module half_subst #(
    parameter int WIDTH      = 1,
    parameter int REGISTERED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic             out_valid
);

    // Per-lane combinational half subtractors.
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] borrow;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign diff[gi]   = a[gi] ^ b[gi];
            assign borrow[gi] = ~a[gi] & b[gi];
        end
    endgenerate

    generate
        if (REGISTERED != 0) begin : g_reg
            logic [WIDTH-1:0] s_q, s_d;
            logic [WIDTH-1:0] c_q, c_d;
            logic             valid_q, valid_d;

            // Results only load on a qualified input; otherwise the last
            // result is held and out_valid drops so consumers see it as stale.
            always_comb begin
                s_d     = s_q;
                c_d     = c_q;
                valid_d = 1'b0;
                if (in_valid) begin
                    s_d     = diff;
                    c_d     = borrow;
                    valid_d = 1'b1;
                end
            end

            // Reset takes priority over in_valid, discarding any in-flight result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_q     <= '0;
                    c_q     <= '0;
                    valid_q <= 1'b0;
                end else begin
                    s_q     <= s_d;
                    c_q     <= c_d;
                    valid_q <= valid_d;
                end
            end

            assign s         = s_q;
            assign c         = c_q;
            assign out_valid = valid_q;
        end else begin : g_comb
            // Pass-through mode: outputs are forced quiet while reset is held.
            assign s         = rst ? '0 : diff;
            assign c         = rst ? '0 : borrow;
            assign out_valid = in_valid & ~rst;
        end
    endgenerate

endmodule

// File: tb/tb_half_subst.sv
// Self-checking bench for half_subst: three instances (8-lane registered,
// 1-lane registered, 8-lane combinational) checked against an arithmetic
// reference model of the lane subtraction.
module tb_half_subst;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a8, b8;
    logic       a1, b1;
    logic       in_valid;

    logic [7:0] s8, c8, sc, cc;
    logic [0:0] s1, c1;
    logic       v8, v1, vc;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state for the registered instances.
    logic [7:0] m_s8 = '0, m_c8 = '0;
    logic       m_s1 = 1'b0, m_c1 = 1'b0;
    logic       m_v  = 1'b0;

    always #5 clk = ~clk;

    half_subst #(.WIDTH(8), .REGISTERED(1)) u_reg8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
        .s(s8), .c(c8), .out_valid(v8)
    );

    half_subst #(.WIDTH(1), .REGISTERED(1)) u_reg1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid),
        .s(s1), .c(c1), .out_valid(v1)
    );

    half_subst #(.WIDTH(8), .REGISTERED(0)) u_comb (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
        .s(sc), .c(cc), .out_valid(vc)
    );

    // Reference: per lane, the signed difference d = a - b in {-1,0,1};
    // the borrow is set when d is negative and the difference bit is |d|.
    function automatic void ref_sub(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] s, output logic [7:0] c);
        for (int i = 0; i < 8; i++) begin
            int d;
            d    = int'(a[i]) - int'(b[i]);
            c[i] = (d < 0);
            s[i] = (d != 0);
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational instance,
    // advance the model at the edge, then check the registered instances.
    task automatic cycle(input string tag, input logic r, input logic [7:0] ai, input logic [7:0] bi,
                         input logic a1i, input logic b1i, input logic vi);
        logic [7:0] rs8, rc8, rs1, rc1;
        rst = r; a8 = ai; b8 = bi; a1 = a1i; b1 = b1i; in_valid = vi;
        ref_sub(ai, bi, rs8, rc8);
        ref_sub({7'b0, a1i}, {7'b0, b1i}, rs1, rc1);
        #1;
        chk({tag, ".comb_s"}, sc, r ? 8'h00 : rs8);
        chk({tag, ".comb_c"}, cc, r ? 8'h00 : rc8);
        chk({tag, ".comb_v"}, vc, vi && !r);
        @(posedge clk);
        if (r) begin
            m_s8 = '0; m_c8 = '0; m_s1 = 1'b0; m_c1 = 1'b0; m_v = 1'b0;
        end else if (vi) begin
            m_s8 = rs8; m_c8 = rc8; m_s1 = rs1[0]; m_c1 = rc1[0]; m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        #1;
        chk({tag, ".s8"}, s8, m_s8);
        chk({tag, ".c8"}, c8, m_c8);
        chk({tag, ".v8"}, v8, m_v);
        chk({tag, ".s1"}, s1, m_s1);
        chk({tag, ".c1"}, c1, m_c1);
        chk({tag, ".v1"}, v1, m_v);
        $display("%0t %s rst=%b a8=%h b8=%h a1=%b b1=%b iv=%b -> s8=%h c8=%h s1=%b c1=%b ov=%b",
                 $time, tag, r, ai, bi, a1i, b1i, vi, s8, c8, s1, c1, v8);
    endtask

    initial begin
        rst = 1'b1; a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset held with active inputs: outputs stay zero.
        cycle("rst0", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        cycle("rst1", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);

        // Truth table on the 1-lane instance, back to back.
        cycle("tt00", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("tt00.lit", {s1, c1}, 2'b00);
        cycle("tt01", 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        chk("tt01.lit", {s1, c1}, 2'b11);
        cycle("tt10", 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("tt10.lit", {s1, c1}, 2'b10);
        cycle("tt11", 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        chk("tt11.lit", {s1, c1}, 2'b00);

        // Hold: valid (0,1) then in_valid low with toggling inputs.
        cycle("hld0", 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle("hold", 1'b0, 8'($urandom), 8'($urandom), k[0], ~k[0], 1'b0);
            chk("hold.lit", {s1, c1, v1}, 3'b110);
        end

        // Multi-lane directed vector.
        cycle("lane", 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1);
        chk("lane.s8lit", s8, 8'h99);
        chk("lane.c8lit", c8, 8'h18);

        // Mid-stream reset then first valid after reset.
        cycle("strm", 1'b0, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b1);
        cycle("mrst", 1'b1, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b1);
        chk("mrst.lit", {s8, c8, v8}, 17'h0);
        cycle("post", 1'b0, 8'h33, 8'h55, 1'b0, 1'b1, 1'b1);

        // Combinational mode directed: a=1, b=0.
        rst = 1'b0; a8 = 8'h01; b8 = 8'h00; in_valid = 1'b1; #1;
        chk("comb.lit", {sc, cc, vc}, {8'h01, 8'h00, 1'b1});
        in_valid = 1'b0; #1;
        chk("comb.vlo", vc, 1'b0);
        @(posedge clk); #1;

        // Toggle pattern: a every 50 ns, b every 100 ns, 1000 ns.
        for (int k = 0; k < 100; k++) begin
            logic ta, tb;
            ta = ((k / 5) % 2) != 0;
            tb = ((k / 10) % 2) != 0;
            cycle("togl", 1'b0, {8{ta}}, {8{tb}}, ta, tb, 1'b1);
        end

        // Random stimulus with occasional reset and gaps.
        for (int k = 0; k < 40; k++) begin
            cycle("rand", ($urandom_range(15) == 0), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
